// File: rtl/portb_uart_tx.sv
// Port B change tracer: queues each new port B value and sends it as an 8N1 UART frame.
// Define PORTB_UART_PARITY_EN to insert an even-parity bit between the data and stop bits.
module portb_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_b_in,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

`ifdef PORTB_UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic [7:0]    prev_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          baud_end;

    // Space check uses the pre-edge count, so a same-edge pop never makes room for a push.
    always_comb begin
        push_req   = (port_b_in != prev_q);
        push_ok    = push_req && (count < DEPTH_C);
        pop        = (state == S_IDLE) && (count != '0);
        baud_end   = (baud_cnt == BAUD_MAX);
        count_next = count + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 8'h00;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            prev_q    <= port_b_in;
            count     <= count_next;
            fifo_full <= (count_next == DEPTH_C);
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= port_b_in;
        if (pop)
            shift_q <= mem[rd_ptr];
    end

    // tx and busy are registered from the current state, so the line lags the FSM by one
    // cycle: the pop cycle stays high and STOP->IDLE->START leaves one idle-high cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            busy <= (state != S_IDLE) || (count != '0);
            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop)
                        state <= S_START;
                end
                S_START: begin
                    tx <= 1'b0;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    tx <= shift_q[bit_cnt];
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef PORTB_UART_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`ifdef PORTB_UART_PARITY_EN
                S_PARITY: begin
                    tx <= ^shift_q;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_portb_uart_tx.sv
// Directed bench for portb_uart_tx at CLK_DIV=4, FIFO_DEPTH=4; frame timing follows
// PORTB_UART_PARITY_EN when it is defined for the build.
module tb_portb_uart_tx;
    localparam int DIV = 4;
`ifdef PORTB_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] port_b_in = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    portb_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .port_b_in(port_b_in), .clr_ovf(clr_ovf),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic       par;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] v, input logic p, input int i);
        if (i == 0)
            return 1'b0;
        if (i <= 8)
            return v[i-1];
`ifdef PORTB_UART_PARITY_EN
        if (i == 9)
            return p;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge with the FSM idle; the next posedge is the change edge N.
    task automatic send_check(input int idx, input logic [7:0] v, input logic p);
        int bad_tx;
        int bad_busy;
        logic exp;
        bad_tx = 0;
        bad_busy = 0;
        port_b_in = v;
        @(posedge clk);
        for (int c = 1; c <= FL + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c >= 2 && c <= FL + 1)
                exp = frame_bit(v, p, (c - 2) / DIV);
            else
                exp = 1'b1;
            if (tx !== exp) begin
                if (bad_tx == 0)
                    $display("FAIL frame%0d_tx: cycle N+%0d got %b, expected %b", idx, c, tx, exp);
                bad_tx++;
            end
            if (c >= 1 && c <= FL + 1 && busy !== 1'b1)
                bad_busy++;
        end
        check($sformatf("frame%0d_bits_bad", idx), bad_tx, 0);
        check($sformatf("frame%0d_busy_held_bad", idx), bad_busy, 0);
        check($sformatf("frame%0d_busy_fall", idx), busy, 1'b0);
    endtask

    logic [7:0] q_vals [5];
    logic       q_pars [5];

    function automatic logic stream_tx(input int j);
        int s;
        for (int k = 0; k < 5; k++) begin
            s = 2 + k * (FL + 1);
            if (j >= s && j < s + FL)
                return frame_bit(q_vals[k], q_pars[k], (j - s) / DIV);
        end
        return 1'b1;
    endfunction

    initial begin
        int bad;
        int jmax;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h07, 1'b1};
        vecs[6] = '{8'h03, 1'b0};
        q_vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        q_pars = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset and idle line
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_full", fifo_full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0)
                bad++;
        end
        check("idle_zero_no_push", bad, 0);

        // Single frames from a table
        for (int i = 0; i < 7; i++)
            send_check(i, vecs[i].val, vecs[i].par);

        // Holding the value must not retrigger
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0)
                bad++;
        end
        check("hold_no_repeat", bad, 0);

        // Fill FIFO, overflow, set-wins-over-clear, frames in order with one-cycle gaps
        port_b_in = 8'h01;
        @(posedge clk);
        bad = 0;
        jmax = 2 + 5 * (FL + 1) + 1;
        for (int j = 0; j <= jmax; j++) begin
            @(negedge clk);
            if (tx !== stream_tx(j)) begin
                if (bad == 0)
                    $display("FAIL fifo_stream: j=%0d got %b, expected %b", j, tx, stream_tx(j));
                bad++;
            end
            if (j == 3) check("fifo_full_at_3", fifo_full, 1'b0);
            if (j == 4) check("fifo_full_at_4", fifo_full, 1'b1);
            if (j == 5) check("overflow_on_drop", overflow, 1'b1);
            if (j == 6) check("overflow_set_wins", overflow, 1'b1);
            if (j < 5)
                port_b_in = 8'h02 + 8'(j);
            else if (j == 5) begin
                port_b_in = 8'h07;
                clr_ovf = 1'b1;
            end else if (j == 6)
                clr_ovf = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        check("fifo_stream_bad", bad, 0);
        check("fifo_drained_busy", busy, 1'b0);
        check("fifo_drained_full", fifo_full, 1'b0);
        check("overflow_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_ovf = 1'b0;
        check("overflow_cleared", overflow, 1'b0);

        // Reset mid-DATA of 0x3C with two entries queued
        port_b_in = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        port_b_in = 8'h11;
        @(posedge clk);
        @(negedge clk);
        port_b_in = 8'h22;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        port_b_in = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_fifo_full", fifo_full, 1'b0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0)
                bad++;
        end
        check("midrst_fifo_empty", bad, 0);
        send_check(7, 8'h3C, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
